comp_sequencer: RTL and testbench

Initiator that drives one CompUnit MAC slice through a complete dot product. It fetches activation and weight pairs from two synchronous-read buffers and issues clear/MAC instruction codes with operands. It then captures the slice's accumulator and returns the result over a valid/ready handshake. It sits between the layer controller (start/len/base) and the CompUnit array.

---
 rtl/comp_sequencer.sv | 137 +++++++++++++
 tb/tb_comp_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/comp_sequencer.sv
// comp_sequencer: walks a CompUnit slice through a dot product of two paired-element buffers and returns the result.
// Element pairs {2k+1, 2k} are read one cycle ahead of their MAC, so STREAM runs exactly ceil(N/2) cycles.
module comp_sequencer #(
  parameter int value_width = 16,
  parameter int addr_width  = 8,
  parameter int len_width   = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [len_width-1:0]     vec_len,
  input  logic [addr_width-1:0]    act_base,
  input  logic [addr_width-1:0]    wgt_base,
  output logic                     busy,
  output logic                     act_rd_en,
  output logic [addr_width-1:0]    act_rd_addr,
  input  logic [2*value_width-1:0] act_rd_data,
  output logic                     wgt_rd_en,
  output logic [addr_width-1:0]    wgt_rd_addr,
  input  logic [2*value_width-1:0] wgt_rd_data,
  output logic [2:0]               instr,
  output logic [value_width-1:0]   A1,
  output logic [value_width-1:0]   W1,
  output logic [value_width-1:0]   A2,
  output logic [value_width-1:0]   W2,
  input  logic [value_width-1:0]   acc_in,
  output logic [value_width-1:0]   result,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     done
);
  localparam int V = value_width;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, RESULT} state_t;
  state_t                  state_q, state_d;
  logic [len_width-1:0]    pairs_q, pairs_d, cnt_q, cnt_d, pairs_n;
  logic                    odd_q, odd_d, last, rd;
  logic [addr_width-1:0]   act_ptr_q, act_ptr_d, wgt_ptr_q, wgt_ptr_d;
  logic [V-1:0]            result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  assign pairs_n = {1'b0, vec_len[len_width-1:1]} + {{(len_width-1){1'b0}}, vec_len[0]};
  assign last = cnt_q == pairs_q - 1'b1;
  always_comb begin
    state_d = state_q;
    pairs_d = pairs_q;
    cnt_d = cnt_q;
    odd_d = odd_q;
    act_ptr_d = act_ptr_q;
    wgt_ptr_d = wgt_ptr_q;
    result_d = result_q;
    result_valid_d = result_valid_q;
    rd = 1'b0;
    done = 1'b0;
    instr = 3'b000;
    A1 = '0;
    W1 = '0;
    A2 = '0;
    W2 = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        pairs_d = pairs_n;
        odd_d = vec_len[0];
        cnt_d = '0;
        act_ptr_d = act_base;
        wgt_ptr_d = wgt_base;
      end
      CLEAR: begin
        rd = pairs_q != '0;
        state_d = rd ? STREAM : WAIT;
      end
      STREAM: begin
        rd = !last;
        cnt_d = cnt_q + 1'b1;
        state_d = last ? WAIT : STREAM;
        // a trailing odd element rides in the A2/W2 lane with the A1/W1 lane zeroed
        if (last && odd_q) begin
          instr = 3'b110;
          A2 = act_rd_data[V-1:0];
          W2 = wgt_rd_data[V-1:0];
        end else begin
          instr = 3'b111;
          A1 = act_rd_data[V-1:0];
          W1 = wgt_rd_data[V-1:0];
          A2 = act_rd_data[2*V-1:V];
          W2 = wgt_rd_data[2*V-1:V];
        end
      end
      WAIT: begin
        instr = 3'b001;
        result_d = acc_in;
        result_valid_d = 1'b1;
        state_d = RESULT;
      end
      RESULT: begin
        instr = 3'b001;
        if (result_ready) begin
          result_valid_d = 1'b0;
          done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd) begin
      act_ptr_d = act_ptr_q + 1'b1;
      wgt_ptr_d = wgt_ptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pairs_q <= '0;
      cnt_q <= '0;
      odd_q <= 1'b0;
      act_ptr_q <= '0;
      wgt_ptr_q <= '0;
      result_q <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pairs_q <= pairs_d;
      cnt_q <= cnt_d;
      odd_q <= odd_d;
      act_ptr_q <= act_ptr_d;
      wgt_ptr_q <= wgt_ptr_d;
      result_q <= result_d;
      result_valid_q <= result_valid_d;
    end
  end
  assign busy = state_q != IDLE;
  assign act_rd_en = rd;
  assign wgt_rd_en = rd;
  assign act_rd_addr = rd ? act_ptr_q : '0;
  assign wgt_rd_addr = rd ? wgt_ptr_q : '0;
  assign result = result_q;
  assign result_valid = result_valid_q;
endmodule

// File: tb/tb_comp_sequencer.sv
// tb_comp_sequencer: directed jobs against an element-level dot-product model with buffer and CompUnit stand-ins.
module tb_comp_sequencer;
  localparam int VW = 16, AW = 8, LW = 9;
  logic clk, rst, start, busy, result_valid, result_ready, done;
  logic [LW-1:0] vec_len;
  logic [AW-1:0] act_base, wgt_base, act_rd_addr, wgt_rd_addr;
  logic act_rd_en, wgt_rd_en;
  logic [2*VW-1:0] act_rd_data, wgt_rd_data;
  logic [2:0] instr;
  logic [VW-1:0] A1, W1, A2, W2, acc, result;
  logic [2*VW-1:0] act_mem [256];
  logic [2*VW-1:0] wgt_mem [256];
  int a_el [16];
  int w_el [16];
  int tests = 0, fails = 0;
  int cyc = 0, e0 = 0, n = 0, p = 0, ab = 0, wb = 0, exp_sum = 0, rd_a = 0, rd_w = 0;
  int t, j;
  logic er;
  bit chk_on = 0;

  comp_sequencer #(.value_width(VW), .addr_width(AW), .len_width(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .act_base(act_base), .wgt_base(wgt_base),
    .busy(busy), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .instr(instr), .A1(A1), .W1(W1), .A2(A2), .W2(W2), .acc_in(acc),
    .result(result), .result_valid(result_valid), .result_ready(result_ready), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // synchronous-read buffers and a CompUnit accumulator stand-in
  always @(posedge clk) begin
    if (act_rd_en) begin act_rd_data <= act_mem[act_rd_addr]; rd_a <= rd_a + 1; end
    if (wgt_rd_en) begin wgt_rd_data <= wgt_mem[wgt_rd_addr]; rd_w <= rd_w + 1; end
    case (instr)
      3'b000: acc <= '0;
      3'b111: acc <= acc + A1 * W1 + A2 * W2;
      3'b110: acc <= acc + A2 * W2;
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // cycle t after acceptance: 1 = CLEAR, 2..p+1 = stream pair t-2, p+2 = WAIT
  always @(negedge clk) if (chk_on) begin
    t = cyc - e0 + 1;
    if (t >= 1 && t <= p + 2) begin
      chk("busy", busy, 1);
      er = (t <= p + 1) && (t - 1 < p);
      chk("act_rd_en", act_rd_en, er);
      chk("wgt_rd_en", wgt_rd_en, er);
      if (er) begin
        chk("act_rd_addr", act_rd_addr, (ab + t - 1) % 256);
        chk("wgt_rd_addr", wgt_rd_addr, (wb + t - 1) % 256);
      end
      if (t == 1) chk("instr_clear", instr, 0);
      else if (t == p + 2) chk("instr_wait", instr, 1);
      else begin
        j = t - 2;
        if (2 * j + 1 < n) begin
          chk("instr_full", instr, 7);
          chk("A1", A1, a_el[2*j] & 16'hFFFF);
          chk("W1", W1, w_el[2*j] & 16'hFFFF);
          chk("A2", A2, a_el[2*j+1] & 16'hFFFF);
          chk("W2", W2, w_el[2*j+1] & 16'hFFFF);
        end else begin
          chk("instr_half", instr, 6);
          chk("A1_zero", A1, 0);
          chk("W1_zero", W1, 0);
          chk("A2_odd", A2, a_el[2*j] & 16'hFFFF);
          chk("W2_odd", W2, w_el[2*j] & 16'hFFFF);
        end
      end
    end
  end

  task automatic start_job(input int nn, input int abase, input int wbase);
    n = nn; p = (nn + 1) / 2; ab = abase; wb = wbase;
    for (int k = 0; k < p; k++) begin
      act_mem[(abase + k) % 256] = {(2*k+1 < nn) ? 16'(a_el[2*k+1]) : 16'hBEEF, 16'(a_el[2*k])};
      wgt_mem[(wbase + k) % 256] = {(2*k+1 < nn) ? 16'(w_el[2*k+1]) : 16'hBEEF, 16'(w_el[2*k])};
    end
    exp_sum = 0;
    for (int i = 0; i < nn; i++) exp_sum = (exp_sum + a_el[i] * w_el[i]) % 65536;
    vec_len = LW'(nn); act_base = AW'(abase); wgt_base = AW'(wbase);
    start = 1; rd_a = 0; rd_w = 0;
    @(posedge clk); #1;
    start = 0; e0 = cyc; chk_on = 1;
  endtask

  task automatic finish_job(input int hold, input int lit);
    int k = 0;
    while (!result_valid && k < 600) begin @(posedge clk); #1; k++; end
    chk("latency", cyc - e0 + 1, p + 3);
    chk("result_model", result, exp_sum);
    chk("result_literal", result, lit);
    chk_on = 0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", result_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_done", done, 0);
      chk("hold_result", result, lit);
      chk("hold_instr", instr, 1);
      chk("hold_rd", act_rd_en | wgt_rd_en, 0);
      if (h == 3) begin start = 1; vec_len = 2; end
      if (h == 4) start = 0;
      @(posedge clk); #1;
    end
    result_ready = 1; #1;
    chk("done_pulse", done, 1);
    @(posedge clk); #1;
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", result_valid, 0);
    chk("act_reads", rd_a, p);
    chk("wgt_reads", rd_w, p);
  endtask

  initial begin
    rst = 1; start = 0; result_ready = 1; vec_len = 0; act_base = 0; wgt_base = 0; acc = 0;
    act_rd_data = 0; wgt_rd_data = 0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", act_rd_en | wgt_rd_en, 0);
    chk("rst_result", result, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    // 1: 1*5+2*6+3*7+4*8
    for (int i = 0; i < 4; i++) begin a_el[i] = i + 1; w_el[i] = i + 5; end
    start_job(4, 3, 100); finish_job(0, 70);
    // 2: odd length ends on a half MAC
    for (int i = 0; i < 3; i++) begin a_el[i] = i + 2; w_el[i] = 10; end
    start_job(3, 50, 60); finish_job(0, 90);
    // 3: empty vector
    start_job(0, 7, 8); finish_job(0, 0);
    // 4: consumer stalls, start pulsed meanwhile; 1+4+9+16+25
    for (int i = 0; i < 5; i++) begin a_el[i] = i + 1; w_el[i] = i + 1; end
    result_ready = 0;
    start_job(5, 10, 20); finish_job(10, 55);
    // 5: base address wrap and accumulator wrap (256*256 == 2^16)
    for (int i = 0; i < 4; i++) begin a_el[i] = 256; w_el[i] = 256; end
    start_job(4, 255, 254); finish_job(0, 0);
    // truncation: 90000 + 70000 mod 65536
    a_el[0] = 300; w_el[0] = 300; a_el[1] = 1000; w_el[1] = 70;
    start_job(2, 128, 129); finish_job(0, 28928);
    // 6: reset in the middle of STREAM, then a clean job
    for (int i = 0; i < 8; i++) begin a_el[i] = i + 1; w_el[i] = 3; end
    start_job(8, 20, 40);
    @(posedge clk); #1; @(posedge clk); #1;
    chk("pre_rst_instr", instr, 7);
    chk_on = 0; #2;
    rst = 1; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_valid", result_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", act_rd_en | wgt_rd_en, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    start_job(8, 20, 40); finish_job(0, 108);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
